// File: rtl/third_div_pkg.sv
// Shared types and constants for the sequential divide-by-three unit.
// Consumed by third_div and third_div_step.
package third_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } third_div_state_t;

  localparam int DIVISOR      = 3;
  // Largest quotient the 4-bit tripler can produce (15 * 3 = 45).
  localparam int TRIPLE_MAX_Q = 15;

endpackage

// File: rtl/third_div_step.sv
// One restoring-division step by three: folds one dividend bit into the
// 2-bit partial remainder and yields the corresponding quotient bit.
module third_div_step
  import third_div_pkg::*;
(
  input  logic [1:0] rem,
  input  logic       dividend_bit,
  output logic [1:0] rem_next,
  output logic       q_bit
);

  logic [2:0] t;

  // rem is always 0..2, so t never exceeds 5 and t-3 always fits in 2 bits.
  assign t        = {rem, dividend_bit};
  assign q_bit    = (t >= 3'(DIVISOR));
  assign rem_next = q_bit ? 2'(t - 3'(DIVISOR)) : t[1:0];

endmodule

// File: rtl/third_div.sv
// Sequential divide-by-three with valid/ready on both sides, one bit per clock.
// Optional range_err output enabled by defining THIRD_DIV_RANGE_CHECK_EN.
module third_div
  import third_div_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [1:0]       remainder,
  output logic             exact
`ifdef THIRD_DIV_RANGE_CHECK_EN
  ,
  output logic             range_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  third_div_state_t state_q, state_d;
  logic [CW-1:0]    count_q;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after WIDTH steps this register holds the complete quotient.
  logic [WIDTH-1:0] work_q;
  logic [1:0]       rem_q;
  logic [1:0]       rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quo_next;
  logic             last_step;

  third_div_step u_step (
    .rem          (rem_q),
    .dividend_bit (work_q[WIDTH-1]),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  assign quo_next  = {work_q[WIDTH-2:0], q_bit};
  assign last_step = (count_q == CW'(1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: defaulting state_d before the case keeps every path assigned, so no
  // latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      work_q    <= '0;
      rem_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      exact     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= in_value;
            rem_q   <= '0;
            count_q <= CW'(WIDTH);
          end
        end
        BUSY: begin
          work_q  <= quo_next;
          rem_q   <= rem_next;
          count_q <= count_q - CW'(1);
          if (last_step) begin
            quotient  <= quo_next;
            remainder <= rem_next;
            exact     <= (rem_next == 2'd0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef THIRD_DIV_RANGE_CHECK_EN
  logic over_range;

  // Narrow dividends can never produce a quotient above the tripler limit.
  if (WIDTH > 4) begin : g_range_cmp
    assign over_range = (quo_next > WIDTH'(TRIPLE_MAX_Q));
  end else begin : g_range_none
    assign over_range = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                range_err <= 1'b0;
    else if (state_q == BUSY && last_step)  range_err <= over_range;
  end
`endif

endmodule

// File: tb/tb_third_div.sv
// Self-checking bench for third_div: directed cases, stall/reset scenarios,
// randomized operands and a full operand sweep against an arithmetic model.
module tb_third_div;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_value;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [1:0]   remainder;
  logic         exact;
`ifdef THIRD_DIV_RANGE_CHECK_EN
  logic         range_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  third_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_value  (in_value),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .exact     (exact)
`ifdef THIRD_DIV_RANGE_CHECK_EN
    ,
    .range_err (range_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present v in IDLE and wait (bounded) for the result; ends on a negedge.
  task automatic start_op(input int v, input string tag);
    int edges;
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    in_valid = 1'b1;
    in_value = W'(v);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_value = W'($urandom);
    edges = 0;
    while (!out_valid && edges < 4 * W) begin
      @(negedge clk);
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(W));
  endtask

  task automatic check_result(input int v, input string tag);
    check({tag, "_quotient"},  32'(quotient),  32'(v / 3));
    check({tag, "_remainder"}, 32'(remainder), 32'(v % 3));
    check({tag, "_exact"},     32'(exact),     32'((v % 3) == 0));
`ifdef THIRD_DIV_RANGE_CHECK_EN
    check({tag, "_range_err"}, 32'(range_err), 32'((v / 3) > 15));
`endif
  endtask

  // Full operation: optional stall with out_ready low, optional ignored
  // in_valid pulse during the stall, then the output handshake.
  task automatic do_op(input int v, input int stall, input bit pulse, input string tag);
    start_op(v, tag);
    check_result(v, tag);
    for (int i = 0; i < stall; i++) begin
      if (pulse && i == 2) begin
        in_valid = 1'b1;
        in_value = W'(9);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_stall_valid"}, 32'(out_valid), 1);
      check({tag, "_stall_q"},     32'(quotient),  32'(v / 3));
      check({tag, "_stall_ready"}, 32'(in_ready),  0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(out_valid), 0);
    check({tag, "_drain_ready"}, 32'(in_ready),  1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_quotient",  32'(quotient),  0);
    check("rst_remainder", 32'(remainder), 0);
    check("rst_exact",     32'(exact),     0);
`ifdef THIRD_DIV_RANGE_CHECK_EN
    check("rst_range_err", 32'(range_err), 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(0,  0, 1'b0, "zero");
    do_op(45, 0, 1'b0, "v45");
    do_op(47, 0, 1'b0, "v47");
    do_op(63, 0, 1'b0, "v63");
    do_op(30, 10, 1'b1, "stall30");
    do_op(12, 0, 1'b0, "after_stall");

    // Reset while BUSY, three steps into an operation.
    in_valid = 1'b1;
    in_value = W'(33);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("busy_in_ready", 32'(in_ready), 0);
    rst = 1'b1;
    #1;
    check("rst_busy_out_valid", 32'(out_valid), 0);
    check("rst_busy_in_ready",  32'(in_ready),  1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(7, 0, 1'b0, "post_rst7");

    // Reset while DONE drops out_valid without a clock edge.
    start_op(20, "done20");
    check("done20_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_done_out_valid", 32'(out_valid), 0);
    check("rst_done_in_ready",  32'(in_ready),  1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      do_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)), 1'b0, "rand");
    end

    for (int v = 0; v < 64; v++) begin
      start_op(v, "sweep");
      check("sweep_identity", 32'(quotient) * 3 + 32'(remainder), 32'(v));
      check("sweep_remainder_range", 32'(remainder < 2'd3), 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
